// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU share arbiter: width defaults,
// arbiter state encoding and the ALU control codes used by both requesters.
package alu_share_arbiter_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_CTRLW = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

    // Codes are only interpreted by the external ALU; the arbiter forwards them untouched.
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_NOP = 5'd0;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_ADD = 5'd1;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_SUB = 5'd2;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_AND = 5'd3;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_OR  = 5'd4;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_XOR = 5'd5;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_SLT = 5'd6;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_BEQ = 5'd7;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_BNE = 5'd8;
    localparam logic [DEFAULT_CTRLW-1:0] ALU_CONTROL_BLT = 5'd9;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and shared-ALU signals between the two requesters,
// the arbiter (slave side) and the environment/ALU (master side).
interface alu_share_arbiter_if #(
    parameter int XLEN  = alu_share_arbiter_pkg::DEFAULT_XLEN,
    parameter int CTRLW = alu_share_arbiter_pkg::DEFAULT_CTRLW
);
    logic             req0_valid;
    logic             req0_ready;
    logic [CTRLW-1:0] req0_alu_control;
    logic [XLEN-1:0]  req0_a;
    logic [XLEN-1:0]  req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [CTRLW-1:0] req1_alu_control;
    logic [XLEN-1:0]  req1_a;
    logic [XLEN-1:0]  req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [XLEN-1:0]  rsp0_result;
    logic             rsp0_flag;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [XLEN-1:0]  rsp1_result;
    logic             rsp1_flag;

    logic [CTRLW-1:0] alu_control;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_result;
    logic             alu_flag;

    modport slave (
        input  req0_valid, req0_alu_control, req0_a, req0_b,
        input  req1_valid, req1_alu_control, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result, alu_flag,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flag,
        output rsp1_valid, rsp1_result, rsp1_flag,
        output alu_control, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_alu_control, req0_a, req0_b,
        output req1_valid, req1_alu_control, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result, alu_flag,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flag,
        input  rsp1_valid, rsp1_result, rsp1_flag,
        input  alu_control, alu_a, alu_b
    );

endinterface

// File: rtl/alu_share_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone valid wins outright, a tie goes to the
// requester named by the priority pointer.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between the execute path (requester 0) and
// the branch/address path (requester 1), with a registered one-deep response.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int CTRLW = DEFAULT_CTRLW
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus
);

    arb_state_e      state;
    logic            pointer;
    logic            owner;
    logic            reset_settle;
    logic [XLEN-1:0] result_q;
    logic            flag_q;
    logic            rsp0_valid_q;
    logic            rsp1_valid_q;
    logic [1:0]      pick;
    logic [1:0]      grant;

    rr_pick2 u_pick (
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .pointer (pointer),
        .grant   (pick)
    );

    // Grants are held off for the first cycle out of reset and while a response is pending.
    assign grant          = (state == ST_IDLE && !reset_settle) ? pick : 2'b00;
    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    always_comb begin
        bus.alu_control = '0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        if (grant[0]) begin
            bus.alu_control = bus.req0_alu_control;
            bus.alu_a       = bus.req0_a;
            bus.alu_b       = bus.req0_b;
        end else if (grant[1]) begin
            bus.alu_control = bus.req1_alu_control;
            bus.alu_a       = bus.req1_a;
            bus.alu_b       = bus.req1_b;
        end
    end

    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp0_result = rsp0_valid_q ? result_q : '0;
    assign bus.rsp1_result = rsp1_valid_q ? result_q : '0;
    assign bus.rsp0_flag   = rsp0_valid_q & flag_q;
    assign bus.rsp1_flag   = rsp1_valid_q & flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pointer      <= 1'b0;
            owner        <= 1'b0;
            result_q     <= '0;
            flag_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            reset_settle <= 1'b1;
        end else begin
            reset_settle <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        result_q     <= bus.alu_result;
                        flag_q       <= bus.alu_flag;
                        owner        <= grant[1];
                        pointer      <= grant[0];
                        rsp0_valid_q <= grant[0];
                        rsp1_valid_q <= grant[1];
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if ((!owner && bus.rsp0_ready) || (owner && bus.rsp1_ready)) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL use parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL use parameter CTRLW, default 5, meaning alu_control width (matches ALU control encoding in defs.v).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have reqN_valid  input  1, reqN_ready  output  1 for N=0 (execute path) and N=1 (branch/address path).
REQ-006 SHALL have reqN_alu_control  input  CTRLW, reqN_a  input  XLEN, reqN_b  input  XLEN per requester.
REQ-007 SHALL have rspN_valid  output  1, rspN_ready  input  1, rspN_result  output  XLEN, rspN_flag  output  1 per requester.
REQ-008 SHALL have alu_control  output  CTRLW, alu_a  output  XLEN, alu_b  output  XLEN, driving the shared combinational ALU.
REQ-009 SHALL have alu_result  input  XLEN, alu_flag  input  1 (branch-condition outcome), returned by the shared ALU same cycle.

Function
REQ-010 SHALL implement FSM states IDLE and RESP.
REQ-011 IDLE: if any reqN_valid, SHALL grant exactly one requester, assert its reqN_ready, drive its control/operands onto alu_* that cycle.
REQ-012 Grant SHALL be round-robin: one valid -> that one; both valid -> requester holding priority pointer.
REQ-013 On handshake (valid&&ready) SHALL capture alu_result/alu_flag into result register, record owner, flip priority pointer to the other requester, go to RESP.
REQ-014 Latency SHALL be exactly 1 cycle: handshake in cycle T -> rspN_valid high in cycle T+1.
REQ-015 RESP: rspN_valid SHALL be high only for owner; result and flag SHALL hold stable until rspN_ready.
REQ-016 RESP with rspN_ready high SHALL return to IDLE next cycle; no new request SHALL be accepted in RESP (both reqN_ready low).
REQ-017 Non-owner rspN_valid SHALL be 0 always; rspN_result/rspN_flag for non-owner SHALL be 0.
REQ-018 In IDLE with no valid, alu_control SHALL be 0, alu_a/alu_b 0, both reqN_ready 0.
REQ-019 reqN_ready SHALL depend only on state, pointer and req*_valid (no combinational path from rsp*_ready).
REQ-020 alu_control SHALL pass through unmodified; arbiter SHALL NOT decode or check it.
REQ-021 Requester dropping valid before grant SHALL be legal; no state change results.
REQ-022 Sustained throughput SHALL be one operation per 2 cycles when rsp_ready held high.

Reset
REQ-023 reset high at clock edge SHALL force state IDLE, pointer to requester 0, result register 0, flag 0, owner 0.
REQ-024 During and one cycle after reset, all reqN_ready and rspN_valid SHALL be 0.
REQ-025 Reset in RESP SHALL discard pending result; no response SHALL be delivered for it.

Structure
REQ-026 State encodings and XLEN/CTRLW defaults SHALL live in shared defs.v alongside existing ALU_CONTROL_* codes.
REQ-027 Round-robin pick SHALL be a sub-module rr_pick2 (inputs valid[1:0], pointer; output grant[1:0], one-hot or zero).
REQ-028 Shared ALU SHALL remain outside this block.

Verification
REQ-029 Req0 only, ADD a=5 b=7 -> req0_ready cycle T, rsp0_valid T+1, rsp0_result=12; pointer -> 1.
REQ-030 Both valid after reset (req0 ADD 1,1; req1 SUB 9,4) -> req0 granted first (result 2), then req1 (result 5) after rsp0 handshake.
REQ-031 Req1 BEQ a=3 b=3, rsp1_ready held low 4 cycles -> rsp1_valid, result, rsp1_flag=1 stable all 4 cycles, both reqN_ready 0.
REQ-032 Reset asserted in RESP -> next cycle IDLE, rsp0_valid/rsp1_valid 0, pointer 0.
REQ-033 Both valid continuously, rsp ready high -> grants alternate 0,1,0,1; one response every 2 cycles.
REQ-034 Random valid/ready for 10k ops vs reference model -> no lost, duplicated or misrouted results.
